// File: rtl/l2_arbiter.sv
// l2_arbiter: merges L1 I-cache and D-cache line traffic onto the single
// unified-L2 request port. One requester is granted at a time and holds the
// grant for the whole L2 transaction. The winner's address, write line and
// op are latched so the L2 sees stable inputs while the L1 changes its own.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_mem_read/_address      I-cache line read request (never writes)
//   i_mem_resp/_rdata        I-cache completion and returned line
//   d_mem_read/_write        D-cache line read / writeback request
//   d_mem_address/_wdata     D-cache address and writeback line
//   d_mem_resp/_rdata        D-cache completion and returned line
//   mem_read/_write          command to L2 (decoded from registered state)
//   mem_address/_wdata       latched address / write line to L2
//   mem_resp/_rdata          L2 completion and line
//
// Configuration macro: L2_ARB_ROUND_ROBIN_EN
//   defined   - simultaneous I/D requests go to the port not served last
//   undefined - fixed priority, D wins every conflict
module l2_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_mem_read,
  input  logic [15:0]  i_mem_address,
  output logic         i_mem_resp,
  output logic [127:0] i_mem_rdata,
  input  logic         d_mem_read,
  input  logic         d_mem_write,
  input  logic [15:0]  d_mem_address,
  input  logic [127:0] d_mem_wdata,
  output logic         d_mem_resp,
  output logic [127:0] d_mem_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [15:0]  mem_address,
  output logic [127:0] mem_wdata,
  input  logic         mem_resp,
  input  logic [127:0] mem_rdata
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state, state_next;
  logic                last_grant, last_grant_next;  // 0: I served last, 1: D
  logic [ADDR_W-1:0]   addr_q, addr_next;
  logic [LINE_W-1:0]   wdata_q, wdata_next;
  logic                op_write_q, op_write_next;
  logic                i_req, d_req, grant_d;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  // Conflict resolution: D wins when it requests, unless rotating and D went last.
`ifdef L2_ARB_ROUND_ROBIN_EN
  assign grant_d = d_req & (~i_req | ~last_grant);
`else
  assign grant_d = d_req;
`endif

  // Data paths: the latches drive L2; returned lines fan out to both L1s
  // and are qualified only by the granted side's resp.
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  // State and latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      addr_q     <= addr_next;
      wdata_q    <= wdata_next;
      op_write_q <= op_write_next;
    end
  end

  // Next-state, grant latching, L2 command decode and resp routing.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    addr_next       = addr_q;
    wdata_next      = wdata_q;
    op_write_next   = op_write_q;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    i_mem_resp      = 1'b0;
    d_mem_resp      = 1'b0;

    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next      = SERVE_D;
          last_grant_next = 1'b1;
          addr_next       = d_mem_address;
          wdata_next      = d_mem_wdata;
          // Read+write together is tolerated by treating it as a writeback.
          op_write_next   = d_mem_write;
        end else if (i_req) begin
          state_next      = SERVE_I;
          last_grant_next = 1'b0;
          addr_next       = i_mem_address;
          op_write_next   = 1'b0;
        end
      end
      SERVE_I: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          // A resp racing a reset is dropped along with the transaction.
          i_mem_resp = ~rst;
          state_next = DONE;
        end
      end
      SERVE_D: begin
        mem_read  = ~op_write_q;
        mem_write = op_write_q;
        if (mem_resp) begin
          d_mem_resp = ~rst;
          state_next = DONE;
        end
      end
      DONE: begin
        // Quiet cycle so the finished requester can drop its request.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter. Stimulus pushes expected L2 commands and
// expected L1 responses into queues; a monitor pops them as the DUT presents
// commands / resps. Per-cycle phases after each falling edge:
//   +0 stimulus drives, +1 L2 model drives, +2 stimulus checks, +3 monitor.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_mem_read;
  logic [15:0]  i_mem_address;
  logic         i_mem_resp;
  logic [127:0] i_mem_rdata;
  logic         d_mem_read, d_mem_write;
  logic [15:0]  d_mem_address;
  logic [127:0] d_mem_wdata;
  logic         d_mem_resp;
  logic [127:0] d_mem_rdata;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;

  l2_arbiter dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  addr;
    logic         rd;
    logic         wr;
    logic [127:0] wdata;
    logic         chk_wdata;
  } cmd_t;

  typedef struct {
    logic         port;   // 0: I, 1: D
    logic [127:0] data;
  } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int resp_count   = 0;

  // L2 model controls.
  logic l2_auto  = 1'b1;
  logic l2_force = 1'b0;
  int   l2_lat   = 3;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [15:0] a, input logic rd, input logic wr,
                          input logic [127:0] wd, input logic chk);
    cmd_t c;
    c.addr = a; c.rd = rd; c.wr = wr; c.wdata = wd; c.chk_wdata = chk;
    cmd_q.push_back(c);
  endtask

  task automatic push_resp(input logic port, input logic [127:0] data);
    resp_t r;
    r.port = port; r.data = data;
    resp_q.push_back(r);
  endtask

  // Wait (bounded) until the monitor has seen 'target' responses.
  task automatic wait_resps(input int target, input int budget, input string name);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (resp_count >= target) return;
    end
    tests_run++;
    tests_failed++;
    $display("FAIL %s: timeout, got %0d resps expected %0d", name, resp_count, target);
  endtask

  // L2 model: answers an active command after l2_lat cycles.
  initial begin
    int cnt;
    cnt = 0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!l2_auto) begin
        cnt      = 0;
        mem_resp = l2_force;
      end else if ((mem_read | mem_write) && !mem_resp) begin
        cnt++;
        if (cnt >= l2_lat) begin
          mem_resp  = 1'b1;
          mem_rdata = (mem_address == 16'h1230) ? {16{8'hA5}} : {8{mem_address}};
          cnt       = 0;
        end
      end else begin
        mem_resp = 1'b0;
        cnt      = 0;
      end
    end
  end

  // Monitor: compares every presented command and resp against the queues.
  initial begin
    logic  active, prev_active, prev_resp, any_resp;
    cmd_t  cur;
    resp_t exp;
    prev_active = 1'b0;
    prev_resp   = 1'b0;
    cur = '{addr: '0, rd: 1'b0, wr: 1'b0, wdata: '0, chk_wdata: 1'b0};
    forever begin
      @(negedge clk);
      #3;
      active   = mem_read | mem_write;
      any_resp = i_mem_resp | d_mem_resp;
      if (prev_resp) check("done_cmd_low", 128'(active), 128'(0));
      if (active && !prev_active) begin
        if (cmd_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL unexpected_cmd: got addr %h expected none", mem_address);
        end else begin
          cur = cmd_q.pop_front();
        end
      end
      if (active) begin
        check("cmd_addr", 128'(mem_address), 128'(cur.addr));
        check("cmd_read", 128'(mem_read), 128'(cur.rd));
        check("cmd_write", 128'(mem_write), 128'(cur.wr));
        if (cur.chk_wdata) check("cmd_wdata", mem_wdata, cur.wdata);
      end
      if (any_resp) begin
        if (resp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL unexpected_resp: got i=%b d=%b expected none", i_mem_resp, d_mem_resp);
        end else begin
          exp = resp_q.pop_front();
          check("resp_d", 128'(d_mem_resp), 128'(exp.port));
          check("resp_i", 128'(i_mem_resp), 128'(!exp.port));
          check("resp_data", exp.port ? d_mem_rdata : i_mem_rdata, exp.data);
        end
        resp_count++;
      end
      prev_active = active;
      prev_resp   = any_resp;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_mem_read", 128'(mem_read), 128'(0));
    check("rst_mem_write", 128'(mem_write), 128'(0));
    check("rst_mem_address", 128'(mem_address), 128'(0));
    check("rst_mem_wdata", mem_wdata, 128'(0));
    check("rst_resps", 128'({i_mem_resp, d_mem_resp}), 128'(0));

    // Lone I read, L2 latency 3.
    l2_lat = 3;
    push_cmd(16'h1230, 1'b1, 1'b0, '0, 1'b0);
    push_resp(1'b0, {16{8'hA5}});
    @(negedge clk);
    i_mem_read = 1'b1; i_mem_address = 16'h1230;
    @(negedge clk); #2;
    check("grant_latency_i", 128'(mem_read), 128'(1));
    wait_resps(1, 20, "lone_i");
    i_mem_read = 1'b0; i_mem_address = '0;

    // Lone D writeback; the D-cache changes address and data mid-transaction.
    push_cmd(16'h4440, 1'b0, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b1);
    push_resp(1'b1, {8{16'h4440}});
    @(negedge clk);
    d_mem_write = 1'b1; d_mem_address = 16'h4440;
    d_mem_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    @(negedge clk);
    d_mem_address = 16'h0000; d_mem_wdata = '0;
    wait_resps(2, 20, "lone_d_write");
    d_mem_write = 1'b0;

    // Illegal D read+write is a writeback; minimum L2 latency.
    l2_lat = 1;
    push_cmd(16'h5550, 1'b0, 1'b1, {8{16'hBEEF}}, 1'b1);
    push_resp(1'b1, {8{16'h5550}});
    @(negedge clk);
    d_mem_read = 1'b1; d_mem_write = 1'b1;
    d_mem_address = 16'h5550; d_mem_wdata = {8{16'hBEEF}};
    wait_resps(3, 20, "illegal_d_op");
    d_mem_read = 1'b0; d_mem_write = 1'b0;

    // Reset during SERVE_D, then an L2 resp arrives that must not be forwarded.
    push_cmd(16'h3000, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    d_mem_read = 1'b1; d_mem_address = 16'h3000;
    @(negedge clk);
    l2_auto = 1'b0; l2_force = 1'b0;
    rst = 1'b1; d_mem_read = 1'b0;
    #2;
    check("pre_rst_mem_read", 128'(mem_read), 128'(1));
    @(negedge clk);
    rst = 1'b0; l2_force = 1'b1;
    #2;
    check("post_rst_mem_read", 128'(mem_read), 128'(0));
    check("post_rst_mem_write", 128'(mem_write), 128'(0));
    check("post_rst_d_resp", 128'(d_mem_resp), 128'(0));
    check("post_rst_address", 128'(mem_address), 128'(0));
    @(negedge clk);
    l2_force = 1'b0;
    @(negedge clk);
    l2_auto = 1'b1;

    // Continuous I/D conflict; after three grants D drops, then I is served.
    l2_lat = 2;
`ifdef L2_ARB_ROUND_ROBIN_EN
    push_cmd(16'h2000, 1'b1, 1'b0, '0, 1'b0); push_resp(1'b1, {8{16'h2000}});
    push_cmd(16'h1000, 1'b1, 1'b0, '0, 1'b0); push_resp(1'b0, {8{16'h1000}});
    push_cmd(16'h2000, 1'b1, 1'b0, '0, 1'b0); push_resp(1'b1, {8{16'h2000}});
`else
    push_cmd(16'h2000, 1'b1, 1'b0, '0, 1'b0); push_resp(1'b1, {8{16'h2000}});
    push_cmd(16'h2000, 1'b1, 1'b0, '0, 1'b0); push_resp(1'b1, {8{16'h2000}});
    push_cmd(16'h2000, 1'b1, 1'b0, '0, 1'b0); push_resp(1'b1, {8{16'h2000}});
`endif
    push_cmd(16'h1000, 1'b1, 1'b0, '0, 1'b0); push_resp(1'b0, {8{16'h1000}});
    @(negedge clk);
    i_mem_read = 1'b1; i_mem_address = 16'h1000;
    d_mem_read = 1'b1; d_mem_address = 16'h2000;
    @(negedge clk); #2;
    check("grant_after_rst", 128'(mem_address), 128'(16'h2000));
    wait_resps(6, 40, "conflict_three");
    d_mem_read = 1'b0;
    wait_resps(7, 20, "conflict_i_last");
    i_mem_read = 1'b0;

    repeat (4) @(negedge clk);
    check("cmd_q_drained", 128'(cmd_q.size()), 128'(0));
    check("resp_q_drained", 128'(resp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port arbiter that sits directly upstream of the unified L2 cache. It merges the split L1 instruction-cache and data-cache miss/writeback traffic into the single L2 request port. It grants one requester at a time and holds the grant for the whole L2 transaction. It latches the winner's address and write data so the L2 sees stable inputs, and routes the L2 response and line data back to the winner only.

## Interface
Parameters: none (widths fixed by `lc3b_types`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `i_mem_read`  in  1  I-cache line read request (the I-cache never writes)
- `i_mem_address`  in  16 (`lc3b_word`)  I-cache line address
- `i_mem_resp`  out  1  I-cache transaction complete
- `i_mem_rdata`  out  128 (`lc3b_cacheline`)  line to I-cache
- `d_mem_read`, `d_mem_write`  in  1 each  D-cache line read / writeback request
- `d_mem_address`  in  16  D-cache line address
- `d_mem_wdata`  in  128  D-cache writeback line
- `d_mem_resp`  out  1  D-cache transaction complete
- `d_mem_rdata`  out  128  line to D-cache
- `mem_read`, `mem_write`  out  1 each  request to L2
- `mem_address`  out  16  latched address to L2
- `mem_wdata`  out  128  latched write line to L2
- `mem_resp`  in  1  L2 transaction complete
- `mem_rdata`  in  128  line from L2

## Operation
State machine with states IDLE, SERVE_I, SERVE_D, and DONE.

- **IDLE**
  - No requests: stay in IDLE.
  - Only I requests: go to SERVE_I.
  - Only D requests (read or write): go to SERVE_D.
  - Both request: the priority rule decides (see Configuration).
  - On a grant, latch into registers: the winner's address, `d_mem_wdata` (D only), and the op. Op is read for I. For D, `d_mem_write` wins if both `d_mem_read` and `d_mem_write` are high (an illegal input that is tolerated this way).
- **SERVE_I / SERVE_D**
  - Drive `mem_read`/`mem_write` from the latched op, and `mem_address`/`mem_wdata` from the latches.
  - Upstream input changes are ignored.
  - On `mem_resp`=1: assert the winner's `*_mem_resp` combinationally in the same cycle, then go to DONE.
- **DONE**
  - One cycle with `mem_read`=`mem_write`=0 and all requests ignored; gives the requester one cycle to drop its request.
  - Then go to IDLE.
- **Response routing**
  - `i_mem_rdata` and `d_mem_rdata` are both wired to `mem_rdata`; this is legal because only the selected `*_mem_resp` qualifies the data.
  - The non-granted requester's `*_mem_resp` is always 0.
- **`last_grant` register**
  - 1-bit register: 0 = I was served last, 1 = D was served last.
  - Updated when a grant is issued.

## Timing
- **Reset values**
  - State = IDLE, `last_grant` = 0.
  - All latches = 0.
  - `mem_read`=`mem_write`=0; `mem_address`=0, `mem_wdata`=0.
  - `i_mem_resp`=`d_mem_resp`=0.
- **Grant latency:** request sampled in IDLE at edge N; L2 command asserted from cycle N+1 (command outputs are registered state decodes).
- **Response latency:** zero added; L2 `mem_resp` in cycle M gives the requester its resp in cycle M. DONE occupies M+1; the next grant can be sampled at the end of M+2.
- **Minimum back-to-back period:** L2 latency + 2 cycles.
- **`mem_resp` outside SERVE_I/SERVE_D:** ignored, no resp forwarded.
- **Reset mid-transaction:** return to IDLE next edge; commands drop. An in-flight L2 resp is not forwarded.
- A request arriving during SERVE_x or DONE is held by the requester and granted from IDLE.

## Configuration
- **`L2_ARB_ROUND_ROBIN_EN` defined:** on a simultaneous I/D request in IDLE, grant the port not served last. With `last_grant`=0 after reset, the first conflict goes to D.
- **`L2_ARB_ROUND_ROBIN_EN` undefined:** fixed priority, D always wins conflicts. `last_grant` is still maintained but unused.

## Test plan
1. **Lone I read:** `i_mem_read`=1 addr 0x1230; L2 resp after 3 cycles with line 0xA5…A5 → `mem_read`=1, `mem_address`=0x1230 from cycle 1. `i_mem_resp`=1 with `i_mem_rdata`=0xA5…A5 in the resp cycle. `d_mem_resp` stays 0; one DONE cycle follows with commands low.
2. **Lone D writeback:** `d_mem_write`=1 addr 0x4440, wdata 0x0123…CDEF; the D-cache changes addr to 0x0000 mid-transaction → `mem_write`=1, `mem_address` stays 0x4440, `mem_wdata` stays 0x0123…CDEF until resp.
3. **Simultaneous requests, round robin on:** I addr 0x1000 and D read addr 0x2000 held continuously → grants go D, I, D; `mem_address` sequence 0x2000, 0x1000, 0x2000.
4. **Simultaneous requests, macro off:** same stimulus → D granted on every conflict; I is served only after D drops its request.
5. **Reset mid-SERVE_D:** `rst`=1 for one cycle during SERVE_D, then `mem_resp`=1 → commands low the next cycle; no `d_mem_resp`; state IDLE.
6. **Illegal D op:** `d_mem_read`=`d_mem_write`=1 → `mem_write`=1, `mem_read`=0.
